aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 39 +++
 rtl/sub_bytes.sv | 13 +
 rtl/aes_key_expand.sv | 119 +++++++++++
 tb/tb_aes_key_expand.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state layout, round constants and the S-box table.
package aes_pkg;

  // byte [r][c] is row r, column c of the 4x4 AES state
  typedef logic [3:0][3:0][7:0] state_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {IDLE, EXPAND} ke_state_e;

  // Entry 0x00 sits in the top byte of the constant.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

endpackage

// File: rtl/sub_bytes.sv
// SubWord: four parallel S-box lookups, purely combinational.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [3:0][7:0] din,
  output logic [3:0][7:0] dout
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign dout[i] = sbox(din[i]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits round keys 0..10, one per rk handshake.
// Optional round-key store and read port enabled by AES_KEY_EXPAND_STORE_EN.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  state_t     key_in,
  output logic       rk_valid,
  input  logic       rk_ready,
  output state_t     rk_data,
  output logic [3:0] rk_idx,
  output logic       rk_last
`ifdef AES_KEY_EXPAND_STORE_EN
  ,
  input  logic [3:0] rd_idx,
  output state_t     rd_key,
  output logic       store_full
`endif
);

  ke_state_e        state;
  logic [3:0][31:0] w, nw;
  logic [31:0]      rot, sub, tmp;
  logic [7:0]       rcon;
  state_t           next_rk;
  logic             key_acc, rk_hs;

  assign key_acc = (state == IDLE) && key_ready && key_valid;
  assign rk_hs   = rk_valid && rk_ready;

  // RotWord of w[3]: rows 1,2,3,0 from the MSB down
  assign rot = {rk_data[1][3], rk_data[2][3], rk_data[3][3], rk_data[0][3]};

  sub_bytes u_sub (
    .din  (rot),
    .dout (sub)
  );

  always_comb begin
    for (int c = 0; c < 4; c++)
      w[c] = {rk_data[0][c], rk_data[1][c], rk_data[2][c], rk_data[3][c]};
    rcon  = (rk_idx < NUM_ROUNDS) ? RCON[rk_idx + 4'd1] : 8'h00;
    tmp   = sub ^ {rcon, 24'h0};
    nw[0] = w[0] ^ tmp;
    nw[1] = w[1] ^ nw[0];
    nw[2] = w[2] ^ nw[1];
    nw[3] = w[3] ^ nw[2];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        next_rk[r][c] = nw[c][31-8*r -: 8];
  end

  // key_ready is registered so it stays low through reset and rises one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      rk_data   <= '0;
      rk_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          key_ready <= 1'b1;
          if (key_acc) begin
            state     <= EXPAND;
            key_ready <= 1'b0;
            rk_valid  <= 1'b1;
            rk_idx    <= '0;
            rk_data   <= key_in;
            rk_last   <= 1'b0;
          end
        end
        EXPAND: begin
          if (rk_hs) begin
            if (rk_idx == NUM_ROUNDS) begin
              state     <= IDLE;
              key_ready <= 1'b1;
              rk_valid  <= 1'b0;
              rk_idx    <= '0;
              rk_data   <= '0;
              rk_last   <= 1'b0;
            end else begin
              rk_data <= next_rk;
              rk_idx  <= rk_idx + 4'd1;
              rk_last <= (rk_idx == NUM_ROUNDS - 4'd1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b0;
          rk_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_KEY_EXPAND_STORE_EN
  state_t store [0:10];

  always_ff @(posedge clk) begin
    if (rk_hs) store[rk_idx] <= rk_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        store_full <= 1'b0;
    else if (key_acc)               store_full <= 1'b0;
    else if (rk_hs && rk_last)      store_full <= 1'b1;
  end

  assign rd_key = (rd_idx <= NUM_ROUNDS) ? store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand against the FIPS-197 AES-128 key schedule.
// Build with AES_KEY_EXPAND_STORE_EN to also exercise the round-key store.
module tb_aes_key_expand;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic       key_ready;
  state_t     key_in = '0;
  logic       rk_valid;
  logic       rk_ready = 1'b0;
  state_t     rk_data;
  logic [3:0] rk_idx;
  logic       rk_last;
`ifdef AES_KEY_EXPAND_STORE_EN
  logic [3:0] rd_idx = '0;
  state_t     rd_key;
  logic       store_full;
`endif

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last)
`ifdef AES_KEY_EXPAND_STORE_EN
    ,
    .rd_idx    (rd_idx),
    .rd_key    (rd_key),
    .store_full(store_full)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [127:0] exp_rk [0:10];
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic state_t to_state(input logic [127:0] v);
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = v[127-8*(4*c+r) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] flat(input state_t s);
    logic [127:0] v;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[127-8*(4*c+r) -: 8] = s[r][c];
    return v;
  endfunction

  task automatic wait_ready();
    int b;
    b = 0;
    while (!key_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("key_ready_wait", key_ready, 1);
  endtask

  // Runs one full expansion, stalling rk_ready with probability (100-pct)%.
  // With hold set, key_valid stays high carrying key2 throughout.
  task automatic expand(input logic [127:0] key, input int pct, input bit hold,
                        input logic [127:0] key2);
    int  idx, budget;
    bit  done;
    wait_ready();
    key_in    = to_state(key);
    key_valid = 1'b1;
    @(negedge clk);
    if (hold) key_in = to_state(key2);
    else      key_valid = 1'b0;
    idx = 0; done = 1'b0; budget = 0;
    while (!done && budget < 400) begin
      chk("rk_valid", rk_valid, 1);
      chk("rk_idx", rk_idx, idx);
      chk($sformatf("rk_data%0d", idx), flat(rk_data), exp_rk[idx]);
      chk("rk_last", rk_last, idx == 10);
      chk("key_ready_busy", key_ready, 0);
      rk_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (rk_ready) begin
        if (idx == 10) done = 1'b1;
        else idx++;
      end
      budget++;
    end
    chk("expand_done", done, 1);
    rk_ready = 1'b0;
    chk("rk_valid_end", rk_valid, 0);
    chk("rk_data_end", flat(rk_data), 0);
    chk("rk_idx_end", rk_idx, 0);
    chk("key_ready_end", key_ready, 1);
  endtask

  initial begin
    int b;
    exp_rk[0]  = KEY;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_rk_data", flat(rk_data), 0);
    chk("rst_rk_last", rk_last, 0);
    chk("rst_key_ready", key_ready, 0);
    rst = 1'b0;
    #1 chk("release_key_ready", key_ready, 0);
    @(negedge clk);
    chk("post_release_key_ready", key_ready, 1);

    // full run, rk_ready tied high
    expand(KEY, 100, 1'b0, '0);
`ifdef AES_KEY_EXPAND_STORE_EN
    chk("store_full", store_full, 1);
    rd_idx = 4'd10;
    #1 chk("rd_key10", flat(rd_key), exp_rk[10]);
    rd_idx = 4'd12;
    #1 chk("rd_key12", flat(rd_key), 0);
    rd_idx = 4'd3;
    #1 chk("rd_key3", flat(rd_key), exp_rk[3]);
`endif

    // random back-pressure
    expand(KEY, 50, 1'b0, '0);

    // key_valid held with a second (all-zero) key during expansion
    expand(KEY, 100, 1'b1, '0);
    @(negedge clk);
    key_valid = 1'b0;
    chk("key2_rk_valid", rk_valid, 1);
    chk("key2_rk_idx", rk_idx, 0);
    chk("key2_rk_data0", flat(rk_data), 0);
`ifdef AES_KEY_EXPAND_STORE_EN
    chk("store_full_clr", store_full, 0);
`endif
    rk_ready = 1'b1;
    @(negedge clk);
    chk("key2_rk_idx1", rk_idx, 1);
    chk("key2_rk_data1", flat(rk_data), 128'h62636363626363636263636362636363);
    b = 0;
    while (rk_valid && b < 30) begin
      @(negedge clk);
      b++;
    end
    rk_ready = 1'b0;
    chk("key2_drained", rk_valid, 0);

    // asynchronous reset in the middle of an expansion
    wait_ready();
    key_in    = to_state(KEY);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rk_idx5", rk_idx, 5);
    chk("mid_rk_data5", flat(rk_data), exp_rk[5]);
    rk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rk_valid", rk_valid, 0);
    chk("async_rk_idx", rk_idx, 0);
    chk("async_rk_data", flat(rk_data), 0);
    chk("async_rk_last", rk_last, 0);
    chk("async_key_ready", key_ready, 0);
    @(negedge clk);
    chk("rst_hold_key_ready", key_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_key_ready", key_ready, 1);
    expand(KEY, 100, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
